// File: rtl/alu_pkg.sv
// Shared opcodes, CCR bit masks and sequencer state encoding for the ALU
// round-robin sequencer and its combinational core.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [3:0] C_MASK = 4'b1000;
  localparam logic [3:0] V_MASK = 4'b0100;
  localparam logic [3:0] N_MASK = 4'b0010;
  localparam logic [3:0] Z_MASK = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_FLAGS = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Only ADD and SUB produce meaningful carry/overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Stateless ALU: (op, a, b) -> (r, c_out, v_out). c_out is the borrow for SUB.
module alu_core
  import alu_pkg::*;
#(
  parameter int op_size = 4
) (
  input  logic [2:0]         op,
  input  logic [op_size-1:0] a,
  input  logic [op_size-1:0] b,
  output logic [op_size-1:0] r,
  output logic               c_out,
  output logic               v_out
);

  localparam int MSB = op_size - 1;

  logic [op_size:0] sum;
  logic [op_size:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    r     = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (op)
      OP_ADD: begin
        r     = sum[MSB:0];
        c_out = sum[op_size];
        v_out = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is set exactly when a < b.
        r     = diff[MSB:0];
        c_out = diff[op_size];
        v_out = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Two-port round-robin front end for alu_core; runs IDLE->EXEC->FLAGS->DONE per op
// and is the sole owner of the {C,V,N,Z} condition code register.
module alu_rr_sequencer
  import alu_pkg::*;
#(
  parameter int op_size = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [2:0]         op0,
  input  logic [op_size-1:0] a0,
  input  logic [op_size-1:0] b0,
  input  logic               req1,
  input  logic [2:0]         op1,
  input  logic [op_size-1:0] a1,
  input  logic [op_size-1:0] b1,
  output logic [1:0]         grant,
  output logic               done0,
  output logic               done1,
  output logic [op_size-1:0] result,
  output logic [3:0]         ccr,
  output logic               busy,
  output logic               illegal,
  output state_t             state_dbg
);

  // Handshake: a requester raises reqN with opN/aN/bN stable and keeps them until
  // doneN pulses; operands are captured only in IDLE, so later changes are ignored,
  // and a req still high after its done counts as a fresh request.

  state_t             state, state_nx;
  logic               rr_last;
  logic [2:0]         op_q;
  logic [op_size-1:0] a_q, b_q;
  logic               c_q, v_q;
  logic [op_size-1:0] alu_r;
  logic               alu_c, alu_v;
  logic               any_req;
  logic               win1;
  logic [3:0]         flags_new;
  logic [3:0]         upd_mask;

  alu_core #(.op_size(op_size)) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .r     (alu_r),
    .c_out (alu_c),
    .v_out (alu_v)
  );

  assign any_req = req0 | req1;
  // On a tie, the port that did not win last time takes the grant.
  assign win1    = req1 & (~req0 | ~rr_last);

  assign flags_new = {c_q, v_q, result[op_size-1], (result == '0)};
  assign upd_mask  = is_arith(op_q) ? (C_MASK | V_MASK | N_MASK | Z_MASK)
                                    : (N_MASK | Z_MASK);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any_req) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_FLAGS;
      S_FLAGS: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant   <= 2'b00;
      result  <= '0;
      ccr     <= 4'b0000;
      rr_last <= 1'b1;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant <= win1 ? 2'b10 : 2'b01;
            op_q  <= win1 ? op1 : op0;
            a_q   <= win1 ? a1 : a0;
            b_q   <= win1 ? b1 : b0;
          end
        end
        S_EXEC: begin
          if (op_q != OP_RSV) begin
            result <= alu_r;
            c_q    <= alu_c;
            v_q    <= alu_v;
          end
        end
        S_FLAGS: begin
          // Logic ops rewrite only N/Z; C/V survive from the last arithmetic op.
          if (op_q != OP_RSV) ccr <= (ccr & ~upd_mask) | (flags_new & upd_mask);
          rr_last <= grant[1];
        end
        S_DONE:  grant <= 2'b00;
        default: grant <= 2'b00;
      endcase
    end
  end

  assign done0     = (state == S_DONE) & grant[0];
  assign done1     = (state == S_DONE) & grant[1];
  assign illegal   = (state == S_DONE) & (op_q == OP_RSV);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
